multi_channel_clock_divider: RTL and testbench
==============================================

Name: multi_channel_clock_divider

Overview:
- Parametrised, multi-channel successor to the single fixed-ratio divider.
- Generates NumChannels independent divided clocks from one MasterClock.
- Each channel has a per-channel enable, a divisor that software can change at run time, odd/even duty handling, single-cycle edge strobes, and a global phase-resync.
- Sits between the board oscillator (125 MHz, 8 ns) and low-rate peripherals: LED blinkers, UART baud ticks, debouncers.

Parameters:
- NumChannels, 4, number of independent output channels (1..16).
- CountWidth, 16, width of the divisor and internal counters.
- DefaultDivisor, 125, full output period in MasterClock cycles, loaded into every channel at reset. Must be ≥ 2.
- ChanWidth, $clog2(NumChannels) (minimum 1), derived, width of LoadChannel.

Ports:
- MasterClock  in  1  sole clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Enable  in  NumChannels  per-channel run enable, sampled on MasterClock.
- LoadValid  in  1  divisor-load request.
- LoadChannel  in  ChanWidth  target channel of the load.
- LoadDivisor  in  CountWidth  new full-period divisor D.
- LoadReady  out  1  load accepted when LoadValid && LoadReady at a rising edge.
- Resync  in  1  single-cycle pulse; restarts the phase of all enabled channels.
- DividedClock  out  NumChannels  divided clock outputs, registered.
- RiseTick  out  NumChannels  one-cycle pulse on the cycle DividedClock first reads 1.
- FallTick  out  NumChannels  one-cycle pulse on the cycle DividedClock first reads 0.
- DivisorError  out  NumChannels  sticky flag: last load to this channel was invalid.

Behaviour:
- Reset (asynchronous, immediate):
  - All counters = 0; all divisors = DefaultDivisor; all pending slots empty.
  - DividedClock = 0, RiseTick = 0, FallTick = 0, DivisorError = 0.
  - LoadReady = 1 after reset.
- Waveform:
  - Per channel: H = D − floor(D/2), i.e. ceil(D/2); L = floor(D/2).
  - If Enable[i] is first sampled high at edge k: DividedClock[i] = 1 from edge k+1 for H cycles, then 0 for L cycles, repeating with period D.
  - Odd D gives the high phase the extra cycle. Examples: D=5 → 11100; D=2 → 10.
- Ticks:
  - RiseTick[i] = 1 exactly in the cycles where DividedClock[i] goes 0→1, including the first high after enable or resync.
  - FallTick[i] = 1 exactly in the cycles where DividedClock[i] goes 1→0.
  - Both are registered and coincide with the DividedClock transition.
- Enable low:
  - On the next edge: DividedClock[i] = 0, counter cleared to 0.
  - FallTick pulses if DividedClock was 1; no ticks otherwise.
  - Re-enabling restarts at the start of the high phase.
- Load handshake:
  - One pending slot per channel.
  - LoadReady = 0 when LoadChannel addresses an in-range channel whose pending slot is full; otherwise 1. LoadReady is combinational from LoadChannel and pending state.
  - An accepted valid divisor (D ≥ 2) goes into the pending slot and clears DivisorError[i].
  - The pending divisor is applied at the channel's next period boundary (the edge where the counter wraps to 0 and DividedClock rises). It is applied immediately if the channel is disabled. The current period is never truncated.
  - An accepted D < 2 is discarded; DivisorError[i] is set, and the current divisor and waveform are unchanged.
  - LoadChannel ≥ NumChannels: accepted (LoadReady = 1) and discarded, with no flag.
- Resync:
  - On the edge sampling Resync = 1, every enabled channel applies any pending divisor and clears its counter.
  - All enabled channels then show DividedClock = 1 with RiseTick on the following cycle, phase-aligned.
  - A channel already high, or already at the start of its high phase, stays 1 and gets no RiseTick. It does get its new full H count.
- Simultaneous events:
  - Enable low with Resync: disable wins.
  - Load accepted on the same edge its channel's pending divisor is applied: not possible, because LoadReady is 0 that cycle (the slot is still full).
  - A load to one channel never affects other channels.
- Widths:
  - The counter compares against D−1 at CountWidth bits; no overflow for any D ≤ 2^CountWidth − 1.
- Reset mid-operation:
  - All outputs drop to reset values immediately.
  - Pending loads are lost.

Test Plan:
- Reset, Enable=4'b0001, default D=125 → ch0 high 63 cycles, low 62, RiseTick every 125 cycles; ch1..3 stay 0.
- Load ch1 D=4, then Enable ch1 → DividedClock[1] pattern 1100 repeating; RiseTick/FallTick each 1 cycle at the transitions.
- Ch2 running D=10, load D=5 at mid-high (cycle 3) → current 10-cycle period completes, then 11100 pattern; a second load before the switch sees LoadReady=0.
- Load ch3 D=1 → DivisorError[3]=1 and waveform unchanged; then load D=6 → flag clears, new period 6 after the boundary.
- Channels D=4 and D=6 enabled with arbitrary phase, pulse Resync → both rise on the same cycle with RiseTick together.
- Assert Reset mid-high on all channels → outputs 0 immediately, divisors back to 125, pending load discarded.

Source files
------------

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock divider: per-channel enable, run-time divisor
// loads through a one-deep pending slot, registered edge strobes and global resync.
module multi_channel_clock_divider #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned CountWidth     = 16,
  parameter int unsigned DefaultDivisor = 125,
  parameter int unsigned ChanWidth      = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   MasterClock,
  input  logic                   Reset,
  input  logic [NumChannels-1:0] Enable,
  input  logic                   LoadValid,
  input  logic [ChanWidth-1:0]   LoadChannel,
  input  logic [CountWidth-1:0]  LoadDivisor,
  output logic                   LoadReady,
  input  logic                   Resync,
  output logic [NumChannels-1:0] DividedClock,
  output logic [NumChannels-1:0] RiseTick,
  output logic [NumChannels-1:0] FallTick,
  output logic [NumChannels-1:0] DivisorError
);

  typedef logic [CountWidth-1:0] cnt_t;

  cnt_t r_cnt  [NumChannels];
  cnt_t r_div  [NumChannels];
  cnt_t r_pdiv [NumChannels];
  cnt_t w_cnt_nxt  [NumChannels];
  cnt_t w_div_nxt  [NumChannels];
  cnt_t w_pdiv_nxt [NumChannels];

  logic [NumChannels-1:0] r_pvalid, r_active, r_clk, r_rise, r_fall, r_err;
  logic [NumChannels-1:0] w_pvalid_nxt, w_active_nxt, w_clk_nxt, w_err_nxt, w_apply;
  logic                   w_in_range, w_accept;

  assign w_in_range = (32'(LoadChannel) < NumChannels);
  assign LoadReady  = !(w_in_range && r_pvalid[LoadChannel]);
  assign w_accept   = LoadValid && LoadReady;

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_pdiv_nxt   = r_pdiv;
    w_pvalid_nxt = r_pvalid;
    w_active_nxt = r_active;
    w_clk_nxt    = r_clk;
    w_err_nxt    = r_err;
    w_apply      = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      if (!Enable[i]) begin
        w_active_nxt[i] = 1'b0;
        w_cnt_nxt[i]    = '0;
        w_clk_nxt[i]    = 1'b0;
        w_apply[i]      = 1'b1;
      end else if (Resync) begin
        w_active_nxt[i] = 1'b1;
        w_cnt_nxt[i]    = '0;
        w_clk_nxt[i]    = 1'b1;
        w_apply[i]      = 1'b1;
      end else if (!r_active[i]) begin
        // Park on the last count so the next edge is an ordinary period boundary.
        w_active_nxt[i] = 1'b1;
        w_cnt_nxt[i]    = r_div[i] - cnt_t'(1);
        w_clk_nxt[i]    = 1'b0;
      end else if (r_cnt[i] == r_div[i] - cnt_t'(1)) begin
        w_cnt_nxt[i]    = '0;
        w_clk_nxt[i]    = 1'b1;
        w_apply[i]      = 1'b1;
      end else begin
        w_cnt_nxt[i]    = r_cnt[i] + cnt_t'(1);
        w_clk_nxt[i]    = (w_cnt_nxt[i] < (r_div[i] - (r_div[i] >> 1)));
      end

      if (w_apply[i] && r_pvalid[i]) begin
        w_div_nxt[i]    = r_pdiv[i];
        w_pvalid_nxt[i] = 1'b0;
      end

      if (w_accept && (32'(LoadChannel) == i)) begin
        if (LoadDivisor >= cnt_t'(2)) begin
          w_pdiv_nxt[i]   = LoadDivisor;
          w_pvalid_nxt[i] = 1'b1;
          w_err_nxt[i]    = 1'b0;
        end else begin
          w_err_nxt[i]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        r_cnt[i]  <= '0;
        r_div[i]  <= cnt_t'(DefaultDivisor);
        r_pdiv[i] <= '0;
      end
      r_pvalid <= '0;
      r_active <= '0;
      r_clk    <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_err    <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_pdiv   <= w_pdiv_nxt;
      r_pvalid <= w_pvalid_nxt;
      r_active <= w_active_nxt;
      r_clk    <= w_clk_nxt;
      r_rise   <= w_clk_nxt & ~r_clk;
      r_fall   <= ~w_clk_nxt & r_clk;
      r_err    <= w_err_nxt;
    end
  end

  assign DividedClock = r_clk;
  assign RiseTick     = r_rise;
  assign FallTick     = r_fall;
  assign DivisorError = r_err;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Directed + randomized bench for multi_channel_clock_divider, checked against a
// cycle-stamp model: each channel remembers when its current period began.
module tb_multi_channel_clock_divider;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic           MasterClock = 1'b0;
  logic           Reset = 1'b1;
  logic [NCH-1:0] Enable = '0;
  logic           LoadValid = 1'b0;
  logic [1:0]     LoadChannel = '0;
  logic [CW-1:0]  LoadDivisor = '0;
  logic           LoadReady;
  logic           Resync = 1'b0;
  logic [NCH-1:0] DividedClock, RiseTick, FallTick, DivisorError;

  multi_channel_clock_divider #(
    .NumChannels(NCH), .CountWidth(CW), .DefaultDivisor(125)
  ) dut (
    .MasterClock(MasterClock), .Reset(Reset), .Enable(Enable),
    .LoadValid(LoadValid), .LoadChannel(LoadChannel), .LoadDivisor(LoadDivisor),
    .LoadReady(LoadReady), .Resync(Resync), .DividedClock(DividedClock),
    .RiseTick(RiseTick), .FallTick(FallTick), .DivisorError(DivisorError)
  );

  always #4 MasterClock = ~MasterClock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int m_dv[NCH], m_start[NCH], m_pend[NCH];
  bit m_run[NCH], m_out[NCH], m_rise[NCH], m_fall[NCH], m_err[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_dv[i] = 125; m_start[i] = 0; m_pend[i] = 0;
      m_run[i] = 0; m_out[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_err[i] = 0;
    end
  endfunction

  function automatic bit model_ready();
    return m_pend[LoadChannel] == 0;
  endfunction

  // One rising edge: period boundaries fall every D cycles after the stamped start.
  function automatic void model_edge();
    bit acc;
    bit o;
    if (Reset) begin
      model_reset();
      return;
    end
    acc = LoadValid && model_ready();
    for (int i = 0; i < NCH; i++) begin
      o = 0;
      if (!Enable[i]) begin
        m_run[i] = 0;
        if (m_pend[i] != 0) begin m_dv[i] = m_pend[i]; m_pend[i] = 0; end
      end else begin
        if (Resync || (m_run[i] && (cyc == m_start[i] || cyc - m_start[i] == m_dv[i]))) begin
          m_start[i] = cyc;
          if (m_pend[i] != 0) begin m_dv[i] = m_pend[i]; m_pend[i] = 0; end
        end else if (!m_run[i]) begin
          m_start[i] = cyc + 1;
        end
        m_run[i] = 1;
        o = (cyc >= m_start[i]) && (cyc - m_start[i] < m_dv[i] - m_dv[i] / 2);
      end
      m_rise[i] = o && !m_out[i];
      m_fall[i] = !o && m_out[i];
      m_out[i]  = o;
    end
    if (acc) begin
      if (LoadDivisor >= 2) begin
        m_pend[LoadChannel] = int'(LoadDivisor);
        m_err[LoadChannel]  = 0;
      end else begin
        m_err[LoadChannel] = 1;
      end
    end
  endfunction

  task automatic check_all();
    logic [NCH-1:0] ec, er, ef, ee;
    for (int i = 0; i < NCH; i++) begin
      ec[i] = m_out[i]; er[i] = m_rise[i]; ef[i] = m_fall[i]; ee[i] = m_err[i];
    end
    chk("DividedClock", 32'(DividedClock), 32'(ec));
    chk("RiseTick", 32'(RiseTick), 32'(er));
    chk("FallTick", 32'(FallTick), 32'(ef));
    chk("DivisorError", 32'(DivisorError), 32'(ee));
    chk("LoadReady", 32'(LoadReady), 32'(model_ready()));
  endtask

  task automatic step();
    @(posedge MasterClock);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load(input int ch, input int d);
    LoadChannel = 2'(ch);
    LoadDivisor = CW'(d);
    LoadValid   = 1'b1;
    step();
    LoadValid   = 1'b0;
  endtask

  task automatic wait_rise(input int ch, input int limit, input string tag);
    int k;
    k = 0;
    while (!m_rise[ch] && k < limit) begin
      step();
      k++;
    end
    chk(tag, 32'(m_rise[ch]), 32'd1);
  endtask

  initial begin
    int hi, rises;
    model_reset();
    #1;
    check_all();
    chk("reset_clk", 32'(DividedClock), 32'd0);
    chk("reset_ready", 32'(LoadReady), 32'd1);
    steps(2);
    @(negedge MasterClock);
    Reset = 1'b0;

    // ch0 at default divisor 125: 63 high, 62 low
    Enable = 4'b0001;
    wait_rise(0, 5, "ch0_first_rise");
    hi = 1; rises = 1;
    for (int k = 0; k < 124; k++) begin
      step();
      hi    += int'(DividedClock[0]);
      rises += int'(RiseTick[0]);
    end
    chk("ch0_high_cycles", 32'(hi), 32'd63);
    chk("ch0_rises_per_period", 32'(rises), 32'd1);
    step();
    chk("ch0_period_rise", 32'(RiseTick[0]), 32'd1);
    chk("ch123_idle", 32'(DividedClock[3:1]), 32'd0);

    // ch1 loaded while disabled, then 1100 pattern
    load(1, 4);
    step();
    Enable = 4'b0011;
    steps(20);

    // ch2 D=10, switch to D=5 mid-high, second load blocked
    load(2, 10);
    step();
    Enable = 4'b0111;
    wait_rise(2, 5, "ch2_first_rise");
    steps(2);
    load(2, 5);
    LoadChannel = 2'd2;
    LoadDivisor = CW'(7);
    LoadValid   = 1'b1;
    #1;
    chk("ch2_busy_ready", 32'(LoadReady), 32'd0);
    step();
    LoadValid = 1'b0;
    steps(30);

    // ch3 invalid then valid divisor
    Enable = 4'b1111;
    steps(3);
    load(3, 1);
    chk("ch3_err_set", 32'(DivisorError[3]), 32'd1);
    steps(10);
    load(3, 6);
    chk("ch3_err_clear", 32'(DivisorError[3]), 32'd0);
    steps(140);

    // resync ch1 (D=4) and ch3 (D=6) from arbitrary phase
    Enable = 4'b1010;
    steps(int'($urandom_range(3, 12)));
    Resync = 1'b1;
    step();
    Resync = 1'b0;
    chk("resync_aligned", 32'({DividedClock[3], DividedClock[1]}), 32'd3);
    steps(12);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 39) == 0) Enable[$urandom_range(0, NCH - 1)] ^= 1'b1;
      LoadValid   = ($urandom_range(0, 9) == 0);
      LoadChannel = 2'($urandom_range(0, NCH - 1));
      LoadDivisor = CW'($urandom_range(0, 12));
      Resync      = ($urandom_range(0, 59) == 0);
      step();
    end
    LoadValid = 1'b0;
    Resync    = 1'b0;

    // all channels high with a pending load, then async reset
    Enable = '0;
    steps(2);
    for (int c = 0; c < NCH; c++) load(c, 8);
    step();
    Enable = '1;
    Resync = 1'b1;
    step();
    Resync = 1'b0;
    load(0, 9);
    chk("pre_reset_high", 32'(DividedClock), 32'hF);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_reset_clk", 32'(DividedClock), 32'd0);
    step();
    @(negedge MasterClock);
    Reset  = 1'b0;
    Enable = 4'b0001;
    wait_rise(0, 5, "post_reset_rise");
    steps(130);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
